imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader for the single-cycle MIPS core. Accepts a byte stream (valid/ready),
//  parses a 16-bit word-count header, packs big-endian bytes into 32-bit instructions and writes
//  them into instruction memory from word address 0. Holds the core in reset until the load completes.
// PARAMETERS
//  ADDR_W   8   instruction-memory word-address width; capacity = 2**ADDR_W words
// PORTS
//  clk         in   1       system clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  start       in   1       1-cycle pulse: begin a load (honoured in IDLE, DONE, ERR only)
//  s_valid     in   1       byte stream valid
//  s_data      in   8       byte stream data
//  s_ready     out  1       loader accepts a byte this cycle
//  imem_we     out  1       instruction-memory write strobe, 1 cycle per word
//  imem_addr   out  ADDR_W  word address of the write
//  imem_wdata  out  32      instruction word
//  cpu_hold    out  1       1 = keep the core in reset
//  done        out  1       load completed successfully (level)
//  err         out  1       load aborted (level)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; s_ready=0, imem_we=0, imem_addr=0, imem_wdata=0,
//    cpu_hold=1, done=0, err=0; byte and word counters cleared. Reset mid-load abandons it.
//  - Byte transfer = s_valid && s_ready on a rising edge. s_ready is 1 only in HDR_HI, HDR_LO,
//    DATA and CSUM. It is registered, never depends combinationally on s_valid.
//  - FSM: IDLE -start-> HDR_HI -byte-> HDR_LO -byte-> {ERR if count > 2**ADDR_W; DONE/CSUM if
//    count==0; else DATA}. DATA takes 4 bytes (MSB first) -> WRITE. WRITE lasts exactly 1 cycle,
//    imem_we=1, then word index++; index==count -> CSUM (if enabled) or DONE; else DATA.
//  - Latency: 4th byte accepted on edge N -> imem_we high during cycle N+1 -> s_ready again in N+2.
//  - imem_addr = word index (0..count-1), held stable while imem_we=1. No wrap: count==2**ADDR_W
//    is legal and the last write goes to address 2**ADDR_W-1.
//  - DONE: done=1, cpu_hold=0, s_ready=0. ERR: err=1, cpu_hold=1, s_ready=0.
//  - start in DONE/ERR: clear done/err, set cpu_hold=1 in the same edge, go to HDR_HI.
//    start in any other state is ignored. s_valid in IDLE/DONE/ERR is ignored (never consumed).
//  - Header count is unsigned 16 bits; comparison against 2**ADDR_W done at ADDR_W+1 bits min.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: after the last word, CSUM state accepts 1 byte; the 8-bit
//    modular sum of all header and data bytes plus this byte must be 0x00 -> DONE, else -> ERR
//    (words already written stay in memory; cpu_hold stays 1).
//  Not defined: no CSUM state; transition from the last WRITE (or count==0) goes directly to DONE.
// STRUCTURE
//  Package imem_loader_pkg: state enum (IDLE, HDR_HI, HDR_LO, DATA, WRITE, CSUM, DONE, ERR),
//    HDR_BYTES=2, BYTES_PER_WORD=4, COUNT_W=16.
//  Sub-module byte_word_packer: shifts in bytes MSB-first, 2-bit byte counter, word_valid pulse
//    on 4th byte, sync clear on start. Top holds FSM, word index, header and checksum logic.
// TESTING
//  1. Reset then start; stream 00 02 | 20 08 00 05 | 20 09 00 0A -> two writes: addr0=0x20080005,
//     addr1=0x2009000A; done=1, cpu_hold=0 one cycle after 2nd write; err=0.
//  2. Same stream with s_valid toggled randomly (50%) -> identical writes/addresses; no byte lost
//     or duplicated; imem_we never asserted twice for one word.
//  3. Header 00 00 -> no imem_we; DONE (no CSUM) straight after HDR_LO; cpu_hold drops.
//  4. ADDR_W=2, header 00 05 -> ERR after 2nd byte; err=1, cpu_hold=1, no writes; start -> err=0.
//  5. rst pulled low after 6 data bytes -> all outputs at reset values asynchronously; new start
//     with full stream reloads from addr 0 correctly.
//  6. CHECKSUM_EN: 00 01 | 00 00 00 01 | FE -> DONE; same with trailer FF -> ERR, cpu_hold=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_HI, S_HDR_LO, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int COUNT_W        = 16;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and core-control status of the loader.
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              start;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport slave (
    input  start, s_valid, s_data,
    output s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
  );

  modport master (
    output start, s_valid, s_data,
    input  s_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader_byte_word_packer.sv
// Packs MSB-first bytes into a word; o_word is combinational so the FSM can latch it on the 4th byte.
module byte_word_packer
  import imem_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_clr,
  input  logic                        i_byte_valid,
  input  logic [7:0]                  i_byte,
  output logic                        o_word_valid,
  output logic [8*BYTES_PER_WORD-1:0] o_word
);
  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]                r_cnt;
  logic [8*(BYTES_PER_WORD-1)-1:0] r_shreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_shreg <= '0;
    end else if (i_byte_valid) begin
      r_cnt   <= r_cnt + 1'b1;
      r_shreg <= {r_shreg[8*(BYTES_PER_WORD-2)-1:0], i_byte};
    end
  end

  assign o_word_valid = i_byte_valid && (r_cnt == CNT_W'(BYTES_PER_WORD - 1));
  assign o_word       = {r_shreg, i_byte};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: header-counted big-endian byte stream -> imem writes from address 0; holds core in reset.
// Optional trailing checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input logic          clk,
  input logic          rst,
  imem_loader_if.slave bus
);
  // Wide enough for both the 16-bit header count and the 2**ADDR_W capacity.
  localparam int CMP_W = max_i(ADDR_W + 1, COUNT_W);

  state_e                 r_state;
  logic                   r_s_ready;
  logic                   r_we;
  logic                   r_cpu_hold;
  logic                   r_done;
  logic                   r_err;
  logic [31:0]            r_wdata;
  logic [ADDR_W:0]        r_idx;
  logic [COUNT_W-1:0]     r_count;
  logic [7:0]             r_hdr_hi;

  logic                   w_xfer;
  logic                   w_start_ok;
  logic                   w_word_valid;
  logic                   w_too_big;
  logic                   w_zero;
  logic                   w_last;
  logic [31:0]            w_word;
  logic [HDR_BYTES*8-1:0] w_hdr_count;
  logic [ADDR_W:0]        w_idx_nxt;

  assign w_xfer      = bus.s_valid && r_s_ready;
  assign w_start_ok  = bus.start && (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_hdr_count = {r_hdr_hi, bus.s_data};
  assign w_too_big   = CMP_W'(w_hdr_count) > (CMP_W'(1) << ADDR_W);
  assign w_zero      = (w_hdr_count == '0);
  assign w_idx_nxt   = r_idx + 1'b1;
  assign w_last      = CMP_W'(w_idx_nxt) == CMP_W'(r_count);

  byte_word_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .i_clr        (w_start_ok),
    .i_byte_valid (w_xfer && (r_state == S_DATA)),
    .i_byte       (bus.s_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] w_sum_nxt;

  assign w_sum_nxt = r_sum + bus.s_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_sum <= '0;
    else if (w_start_ok) r_sum <= '0;
    else if (w_xfer)     r_sum <= w_sum_nxt;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_s_ready  <= 1'b0;
      r_we       <= 1'b0;
      r_cpu_hold <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wdata    <= '0;
      r_idx      <= '0;
      r_count    <= '0;
      r_hdr_hi   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (w_start_ok) begin
            r_state    <= S_HDR_HI;
            r_s_ready  <= 1'b1;
            r_cpu_hold <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_idx      <= '0;
          end
        end
        S_HDR_HI: begin
          if (w_xfer) begin
            r_hdr_hi <= bus.s_data;
            r_state  <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          if (w_xfer) begin
            r_count <= w_hdr_count;
            if (w_too_big) begin
              r_state   <= S_ERR;
              r_s_ready <= 1'b0;
              r_err     <= 1'b1;
            end else if (w_zero) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              r_state    <= S_CSUM;
`else
              r_state    <= S_DONE;
              r_s_ready  <= 1'b0;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          // Stall the stream for the write cycle so addr/data stay stable under imem_we.
          if (w_word_valid) begin
            r_state   <= S_WRITE;
            r_s_ready <= 1'b0;
            r_we      <= 1'b1;
            r_wdata   <= w_word;
          end
        end
        S_WRITE: begin
          r_we  <= 1'b0;
          r_idx <= w_idx_nxt;
          if (w_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_state    <= S_CSUM;
            r_s_ready  <= 1'b1;
`else
            r_state    <= S_DONE;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
`endif
          end else begin
            r_state   <= S_DATA;
            r_s_ready <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_xfer) begin
            r_s_ready <= 1'b0;
            if (w_sum_nxt == 8'h00) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state   <= S_IDLE;
          r_s_ready <= 1'b0;
          r_we      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready    = r_s_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_idx[ADDR_W-1:0];
  assign bus.imem_wdata = r_wdata;
  assign bus.cpu_hold   = r_cpu_hold;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule
